// File: rtl/hazard_ctrl_mdu_pkg.sv
// Shared definitions for the hazard unit: forwarding select codes and MDU sequencer states.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;

  // The MEM result is younger than the WB result, so MEM wins.
  function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_if.sv
// Pipeline-side bundle of the hazard unit; HAZARD_PERF_CNT_EN adds the stall counters.
interface hazard_ctrl_mdu_if #(
  parameter int REG_AW = 5
);
  logic              BranchD, JumpRD;
  logic              MemReadE, MemReadM;
  logic              RegWriteE, RegWriteM, RegWriteW;
  logic [REG_AW-1:0] RsD, RtD, RsE, RtE;
  logic [REG_AW-1:0] WriteRegE, WriteRegM, WriteRegW;
  logic              MduStartE, MduIsDivE;
  logic [1:0]        ForwardAE, ForwardBE, ForwardAD, ForwardBD;
  logic              StallF, StallD, StallE;
  logic              FlushE, FlushM;
  logic              MduBusy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]       PerfLwCnt, PerfBrCnt, PerfMduCnt;
`endif

  modport master (
    output BranchD, JumpRD, MemReadE, MemReadM, RegWriteE, RegWriteM, RegWriteW,
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW, MduStartE, MduIsDivE,
    input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
    input  StallF, StallD, StallE, FlushE, FlushM, MduBusy
`ifdef HAZARD_PERF_CNT_EN
    , input PerfLwCnt, PerfBrCnt, PerfMduCnt
`endif
  );

  modport slave (
    input  BranchD, JumpRD, MemReadE, MemReadM, RegWriteE, RegWriteM, RegWriteW,
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW, MduStartE, MduIsDivE,
    output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
    output StallF, StallD, StallE, FlushE, FlushM, MduBusy
`ifdef HAZARD_PERF_CNT_EN
    , output PerfLwCnt, PerfBrCnt, PerfMduCnt
`endif
  );

endinterface

// File: rtl/hazard_ctrl_mdu_fsm.sv
// MDU stall sequencer: holds EX for exactly LAT cycles per mult/div, then one DONE cycle.
module mdu_stall_fsm
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mdu_start,
  input  logic mdu_is_div,
  output logic mdu_stall,
  output logic mdu_busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 2);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 2);

  mdu_state_t    state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MDU_IDLE;
      cnt      <= '0;
      mdu_busy <= 1'b0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (mdu_start) begin
            cnt      <= mdu_is_div ? DIV_LOAD : MUL_LOAD;
            state    <= MDU_BUSY;
            mdu_busy <= 1'b1;
          end
        end
        MDU_BUSY: begin
          if (cnt != '0) cnt   <= cnt - CW'(1);
          else           state <= MDU_DONE;
        end
        MDU_DONE: begin
          state    <= MDU_IDLE;
          mdu_busy <= 1'b0;
        end
        default: begin
          state    <= MDU_IDLE;
          cnt      <= '0;
          mdu_busy <= 1'b0;
        end
      endcase
    end
  end

  // The IDLE start term is gated by rst_n so a reset leaves no stall pending.
  assign mdu_stall = (rst_n & (state == MDU_IDLE) & mdu_start) | (state == MDU_BUSY);

endmodule

// File: rtl/hazard_ctrl_mdu.sv
// Hazard unit for the 5-stage MIPS pipeline: forwarding, load-use, branch/JR and MDU stalls.
// Optional HAZARD_PERF_CNT_EN adds saturating per-source stall-cycle counters.
module hazard_ctrl_mdu
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input logic               clk,
  input logic               rst_n,
  hazard_ctrl_mdu_if.slave  bus
);

  function automatic logic reg_hit(input logic we, input logic [REG_AW-1:0] wr,
                                   input logic [REG_AW-1:0] r);
    return we && (wr != '0) && (wr == r);
  endfunction

  logic mdu_stall, lwstall, brstall;
  logic hit_e, hit_m;

  always_comb begin
    bus.ForwardAE = fwd_sel(reg_hit(bus.RegWriteM, bus.WriteRegM, bus.RsE),
                            reg_hit(bus.RegWriteW, bus.WriteRegW, bus.RsE));
    bus.ForwardBE = fwd_sel(reg_hit(bus.RegWriteM, bus.WriteRegM, bus.RtE),
                            reg_hit(bus.RegWriteW, bus.WriteRegW, bus.RtE));
    bus.ForwardAD = fwd_sel(reg_hit(bus.RegWriteM, bus.WriteRegM, bus.RsD),
                            reg_hit(bus.RegWriteW, bus.WriteRegW, bus.RsD));
    bus.ForwardBD = fwd_sel(reg_hit(bus.RegWriteM, bus.WriteRegM, bus.RtD),
                            reg_hit(bus.RegWriteW, bus.WriteRegW, bus.RtD));
  end

  always_comb begin
    lwstall = reg_hit(bus.MemReadE, bus.WriteRegE, bus.RsD) |
              reg_hit(bus.MemReadE, bus.WriteRegE, bus.RtD);
    // jr/jalr only read Rs; Rt hits count for branches alone.
    hit_e   = reg_hit(bus.RegWriteE, bus.WriteRegE, bus.RsD) |
              (bus.BranchD & reg_hit(bus.RegWriteE, bus.WriteRegE, bus.RtD));
    hit_m   = reg_hit(bus.MemReadM, bus.WriteRegM, bus.RsD) |
              (bus.BranchD & reg_hit(bus.MemReadM, bus.WriteRegM, bus.RtD));
    brstall = (bus.BranchD | bus.JumpRD) & (hit_e | hit_m);
  end

  mdu_stall_fsm #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_mdu (
    .clk        (clk),
    .rst_n      (rst_n),
    .mdu_start  (bus.MduStartE),
    .mdu_is_div (bus.MduIsDivE),
    .mdu_stall  (mdu_stall),
    .mdu_busy   (bus.MduBusy)
  );

  always_comb begin
    bus.StallF = mdu_stall | lwstall | brstall;
    bus.StallD = mdu_stall | lwstall | brstall;
    bus.StallE = mdu_stall;
    bus.FlushM = mdu_stall;
    bus.FlushE = (lwstall | brstall) & ~mdu_stall;
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.PerfLwCnt  <= '0;
      bus.PerfBrCnt  <= '0;
      bus.PerfMduCnt <= '0;
    end else begin
      if (lwstall   && bus.PerfLwCnt  != '1) bus.PerfLwCnt  <= bus.PerfLwCnt  + 32'd1;
      if (brstall   && bus.PerfBrCnt  != '1) bus.PerfBrCnt  <= bus.PerfBrCnt  + 32'd1;
      if (mdu_stall && bus.PerfMduCnt != '1) bus.PerfMduCnt <= bus.PerfMduCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_mdu.sv
// Randomized self-checking bench for hazard_ctrl_mdu against a cycle-phase reference model.
module tb_hazard_ctrl_mdu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_mdu_if #(.REG_AW(5)) hif ();
  hazard_ctrl_mdu_if #(.REG_AW(5)) h2 ();

  hazard_ctrl_mdu #(.REG_AW(5), .MUL_LAT(4), .DIV_LAT(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(hif)
  );
  // Second instance at the minimum latency, fed the same stimulus.
  hazard_ctrl_mdu #(.REG_AW(5), .MUL_LAT(2), .DIV_LAT(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(h2)
  );

  assign h2.BranchD   = hif.BranchD;   assign h2.JumpRD    = hif.JumpRD;
  assign h2.MemReadE  = hif.MemReadE;  assign h2.MemReadM  = hif.MemReadM;
  assign h2.RegWriteE = hif.RegWriteE; assign h2.RegWriteM = hif.RegWriteM;
  assign h2.RegWriteW = hif.RegWriteW;
  assign h2.RsD = hif.RsD; assign h2.RtD = hif.RtD;
  assign h2.RsE = hif.RsE; assign h2.RtE = hif.RtE;
  assign h2.WriteRegE = hif.WriteRegE; assign h2.WriteRegM = hif.WriteRegM;
  assign h2.WriteRegW = hif.WriteRegW;
  assign h2.MduStartE = hif.MduStartE; assign h2.MduIsDivE = hif.MduIsDivE;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  // Model: ph = cycles since the MDU op started (0 = no op in EX).
  int ph [2]  = '{0, 0};
  int lat [2] = '{0, 0};
  int mul_lat [2] = '{4, 2};
  int div_lat [2] = '{32, 3};
  int unsigned lw_n = 0, br_n = 0, mdu_n = 0;
  int unsigned stall_seen = 0, busy_seen = 0, flushe_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] r);
    if (hif.RegWriteM && hif.WriteRegM != 5'd0 && hif.WriteRegM == r) return 2'b10;
    if (hif.RegWriteW && hif.WriteRegW != 5'd0 && hif.WriteRegW == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic exp_lw();
    return hif.MemReadE && hif.WriteRegE != 5'd0 &&
           (hif.WriteRegE == hif.RsD || hif.WriteRegE == hif.RtD);
  endfunction

  function automatic logic exp_br();
    logic reads_e, reads_m;
    reads_e = (hif.WriteRegE == hif.RsD) || (hif.BranchD && hif.WriteRegE == hif.RtD);
    reads_m = (hif.WriteRegM == hif.RsD) || (hif.BranchD && hif.WriteRegM == hif.RtD);
    return (hif.BranchD || hif.JumpRD) &&
           ((hif.RegWriteE && hif.WriteRegE != 5'd0 && reads_e) ||
            (hif.MemReadM && hif.WriteRegM != 5'd0 && reads_m));
  endfunction

  function automatic logic exp_mdu(input int k);
    return rst_n && ((ph[k] == 0 && hif.MduStartE) || (ph[k] >= 1 && ph[k] < lat[k]));
  endfunction

  // Entered at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic run_cycle();
    logic lw, br, m0, m1;
    #1;
    lw = exp_lw(); br = exp_br(); m0 = exp_mdu(0); m1 = exp_mdu(1);
    check("fwd_ae", 32'(hif.ForwardAE), 32'(exp_fwd(hif.RsE)));
    check("fwd_be", 32'(hif.ForwardBE), 32'(exp_fwd(hif.RtE)));
    check("fwd_ad", 32'(hif.ForwardAD), 32'(exp_fwd(hif.RsD)));
    check("fwd_bd", 32'(hif.ForwardBD), 32'(exp_fwd(hif.RtD)));
    check("stall_f", 32'(hif.StallF), 32'(m0 | lw | br));
    check("stall_d", 32'(hif.StallD), 32'(m0 | lw | br));
    check("stall_e", 32'(hif.StallE), 32'(m0));
    check("flush_m", 32'(hif.FlushM), 32'(m0));
    check("flush_e", 32'(hif.FlushE), 32'((lw | br) & ~m0));
    check("busy", 32'(hif.MduBusy), 32'(ph[0] >= 1));
    check("stall_e_lat2", 32'(h2.StallE), 32'(m1));
    check("busy_lat2", 32'(h2.MduBusy), 32'(ph[1] >= 1));
    if (hif.StallE)  stall_seen++;
    if (hif.MduBusy) busy_seen++;
    if (hif.FlushE)  flushe_seen++;
    @(posedge clk);
    if (!rst_n) begin
      lw_n = 0; br_n = 0; mdu_n = 0;
    end else begin
      if (lw) lw_n++;
      if (br) br_n++;
      if (m0) mdu_n++;
    end
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) ph[k] = 0;
      else if (ph[k] == 0) begin
        if (hif.MduStartE) begin
          ph[k]  = 1;
          lat[k] = hif.MduIsDivE ? div_lat[k] : mul_lat[k];
        end
      end else if (ph[k] < lat[k]) ph[k]++;
      else ph[k] = 0;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    hif.BranchD = 0; hif.JumpRD = 0; hif.MemReadE = 0; hif.MemReadM = 0;
    hif.RegWriteE = 0; hif.RegWriteM = 0; hif.RegWriteW = 0;
    hif.RsD = 0; hif.RtD = 0; hif.RsE = 0; hif.RtE = 0;
    hif.WriteRegE = 0; hif.WriteRegM = 0; hif.WriteRegW = 0;
    hif.MduStartE = 0; hif.MduIsDivE = 0;
  endtask

  task automatic rand_inputs();
    hif.BranchD   = ($urandom_range(0, 3) == 0);
    hif.JumpRD    = ($urandom_range(0, 5) == 0);
    hif.MemReadE  = ($urandom_range(0, 2) == 0);
    hif.MemReadM  = ($urandom_range(0, 2) == 0);
    hif.RegWriteE = 1'($urandom_range(0, 1));
    hif.RegWriteM = 1'($urandom_range(0, 1));
    hif.RegWriteW = 1'($urandom_range(0, 1));
    hif.RsD = 5'($urandom_range(0, 3)); hif.RtD = 5'($urandom_range(0, 3));
    hif.RsE = 5'($urandom_range(0, 3)); hif.RtE = 5'($urandom_range(0, 3));
    hif.WriteRegE = 5'($urandom_range(0, 3));
    hif.WriteRegM = 5'($urandom_range(0, 3));
    hif.WriteRegW = 5'($urandom_range(0, 3));
    hif.MduStartE = ($urandom_range(0, 5) == 0);
    hif.MduIsDivE = ($urandom_range(0, 3) == 0);
  endtask

  task automatic mdu_run(input logic is_div, input int hold, input int unsigned want);
    clear_inputs();
    stall_seen = 0; busy_seen = 0; flushe_seen = 0;
    hif.MduStartE = 1; hif.MduIsDivE = is_div;
    for (int i = 0; i < hold; i++) run_cycle();
    hif.MduStartE = 0;
    for (int i = 0; i < 3; i++) run_cycle();
    check("mdu_stall_cycles", stall_seen, want);
    check("mdu_busy_cycles", busy_seen, want);
    check("mdu_flush_e_cycles", flushe_seen, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    @(negedge clk);
    run_cycle();
    run_cycle();
    rst_n = 1;
    run_cycle();

    // Forwarding priority and register 0
    clear_inputs();
    hif.RegWriteM = 1; hif.WriteRegM = 8; hif.RegWriteW = 1; hif.WriteRegW = 8; hif.RsE = 8;
    #1 check("t1_fwd_mem", 32'(hif.ForwardAE), 32'(2'b10));
    run_cycle();
    hif.WriteRegM = 0;
    #1 check("t1_fwd_wb", 32'(hif.ForwardAE), 32'(2'b01));
    run_cycle();

    // Load-use stall, then same with destination r0
    clear_inputs();
    hif.MemReadE = 1; hif.WriteRegE = 9; hif.RtD = 9;
    #1 check("t2_lw_stall", 32'({hif.StallF, hif.StallD, hif.FlushE, hif.StallE}), 32'(4'b1110));
    run_cycle();
    hif.WriteRegE = 0; hif.RtD = 0;
    #1 check("t2_lw_r0", 32'({hif.StallF, hif.FlushE}), 32'(2'b00));
    run_cycle();

    // Branch stall on EX then MEM producer, released once the value reaches WB
    clear_inputs();
    hif.BranchD = 1; hif.RsD = 4; hif.RegWriteE = 1; hif.WriteRegE = 4;
    #1 check("t3_br_ex", 32'(hif.StallD), 32'(1));
    run_cycle();
    hif.RegWriteE = 0; hif.WriteRegE = 0; hif.MemReadM = 1; hif.WriteRegM = 4;
    #1 check("t3_br_mem", 32'(hif.StallD), 32'(1));
    run_cycle();
    hif.MemReadM = 0; hif.WriteRegM = 0; hif.RegWriteW = 1; hif.WriteRegW = 4;
    #1 check("t3_br_wb", 32'({hif.StallD, hif.ForwardAD}), 32'(3'b001));
    run_cycle();

    // MDU sequences: op stays in EX for LAT+1 cycles
    mdu_run(1'b1, 33, 32);
    mdu_run(1'b0, 5, 4);

    // Asynchronous reset in the middle of a divide
    clear_inputs();
    hif.MduStartE = 1; hif.MduIsDivE = 1;
    for (int i = 0; i < 10; i++) run_cycle();
    #2;
    rst_n = 0;
    #1;
    check("t5_rst_stall_e", 32'(hif.StallE), 32'(0));
    check("t5_rst_busy", 32'(hif.MduBusy), 32'(0));
    check("t5_rst_busy_lat2", 32'(h2.MduBusy), 32'(0));
    ph[0] = 0; ph[1] = 0;
    @(negedge clk);
    hif.MduStartE = 0;
    run_cycle();
    rst_n = 1;
    run_cycle();
    run_cycle();

`ifdef HAZARD_PERF_CNT_EN
    rst_n = 0;
    run_cycle();
    rst_n = 1;
    clear_inputs();
    hif.MemReadE = 1; hif.WriteRegE = 9; hif.RtD = 9;
    run_cycle();
    mdu_run(1'b0, 5, 4);
    check("perf_lw_dir", hif.PerfLwCnt, 1);
    check("perf_mdu_dir", hif.PerfMduCnt, 4);
    check("perf_br_dir", hif.PerfBrCnt, 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      run_cycle();
    end

`ifdef HAZARD_PERF_CNT_EN
    check("perf_lw", hif.PerfLwCnt, lw_n);
    check("perf_br", hif.PerfBrCnt, br_n);
    check("perf_mdu", hif.PerfMduCnt, mdu_n);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
